// File: rtl/memio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/DIVISOR registers, byte FIFO, 8N1 shifter.
// Define MEMIO_UART_TX_PARITY_EN to insert an even-parity bit before stop (8E1 framing).
module memio_uart_tx #(
    parameter logic [29:0] BASE_ADDR  = 30'h44,
    parameter logic [15:0] DIV_RESET  = 16'd207,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        re,
    input  logic        we,
    input  logic [29:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rsel,
    output logic        txd
);

    localparam int AW = $clog2(FIFO_DEPTH);

`ifdef MEMIO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t       state;
    logic [15:0]  divisor;
    logic [15:0]  period;
    logic [15:0]  baud_cnt;
    logic [2:0]   bit_cnt;
    logic [7:0]   shreg;
    logic         overflow;
`ifdef MEMIO_UART_TX_PARITY_EN
    logic         par;
`endif

    logic [7:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic hit_tx, hit_st, hit_dv;
    logic full, empty, busy, bit_end;
    logic push, pop, ovf_set, st_rd;
    logic [7:0]  head;
    logic [31:0] status;
    logic unused;

    assign hit_tx  = (addr == BASE_ADDR);
    assign hit_st  = (addr == BASE_ADDR + 30'd1);
    assign hit_dv  = (addr == BASE_ADDR + 30'd2);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign busy    = (state != IDLE);
    assign bit_end = (baud_cnt == period);
    assign head    = mem[rd_ptr];
    assign unused  = ^wdata[31:16];

    // Full is sampled before any same-edge pop, so a write at full is always dropped.
    assign push    = we && hit_tx && !full;
    assign ovf_set = we && hit_tx && full;
    assign st_rd   = re && hit_st;
    assign pop     = !empty && (state == IDLE || (state == STOP && bit_end));
    assign status  = {17'b0, 7'(count), 4'b0, overflow, busy, empty, full};

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divisor  <= DIV_RESET;
            overflow <= 1'b0;
            rdata    <= '0;
            rsel     <= 1'b0;
        end else begin
            if (we && hit_dv) divisor <= wdata[15:0];
            // Set has priority over the read-clear in the same edge.
            if (st_rd)   overflow <= 1'b0;
            if (ovf_set) overflow <= 1'b1;
            rsel  <= re && (hit_tx || hit_st || hit_dv);
            rdata <= '0;
            if (re && hit_st)      rdata <= status;
            else if (re && hit_dv) rdata <= {16'b0, divisor};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            txd      <= 1'b1;
            period   <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef MEMIO_UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            baud_cnt <= (state == IDLE || bit_end) ? 16'd0 : baud_cnt + 16'd1;
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shreg  <= head;
                        period <= divisor;
                        state  <= START;
                        txd    <= 1'b0;
`ifdef MEMIO_UART_TX_PARITY_EN
                        par    <= ^head;
`endif
                    end
                end
                START: if (bit_end) begin
                    state   <= DATA;
                    txd     <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_cnt <= 3'd0;
                end
                DATA: if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
`ifdef MEMIO_UART_TX_PARITY_EN
                        state <= PARITY;
                        txd   <= par;
`else
                        state <= STOP;
                        txd   <= 1'b1;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        txd     <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
`ifdef MEMIO_UART_TX_PARITY_EN
                PARITY: if (bit_end) begin
                    state <= STOP;
                    txd   <= 1'b1;
                end
`endif
                STOP: if (bit_end) begin
                    // Chain straight into the next START so queued frames are contiguous.
                    if (pop) begin
                        shreg  <= head;
                        period <= divisor;
                        state  <= START;
                        txd    <= 1'b0;
`ifdef MEMIO_UART_TX_PARITY_EN
                        par    <= ^head;
`endif
                    end else begin
                        state <= IDLE;
                        txd   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memio_uart_tx.sv
// Directed bench for memio_uart_tx: register-access vector table plus frame-level sequences.
module tb_memio_uart_tx;

    localparam logic [29:0] BASE = 30'h44;
`ifdef MEMIO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        re = 1'b0, we = 1'b0;
    logic [29:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rsel, txd;

    int checks = 0;
    int errors = 0;

    memio_uart_tx dut (
        .clk(clk), .rst(rst_n), .re(re), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .rsel(rsel), .txd(txd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        w;
        logic [29:0] a;
        logic [31:0] d;
        logic        exp_rsel;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endfunction

    // Caller is #1 after a posedge; returns #1 after the edge that sampled the request.
    task automatic bus(input logic r, input logic w, input logic [29:0] a, input logic [31:0] d,
                       output logic rs, output logic [31:0] rd);
        re = r; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        re = 1'b0; we = 1'b0;
        rs = rsel; rd = rdata;
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d);
        logic rs; logic [31:0] rd;
        bus(1'b0, 1'b1, a, d, rs, rd);
    endtask

    task automatic rd_chk(input string name, input logic [29:0] a, input logic [31:0] exp);
        logic rs; logic [31:0] rd;
        bus(1'b1, 1'b0, a, 32'h0, rs, rd);
        chk({name, ".rsel"}, {31'b0, rs}, 32'd1);
        chk(name, rd, exp);
    endtask

    // Entered #1 after the edge that starts the frame (minus skip cycles already elapsed).
    task automatic check_frame(input logic [7:0] b, input int per, input int skip);
        logic [10:0] bits;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef MEMIO_UART_TX_PARITY_EN
        bits[9] = ^b;
`endif
        for (int k = skip; k < NB * per; k++) begin
            chk($sformatf("frame_%02h_cyc%0d", b, k), {31'b0, txd}, {31'b0, bits[k / per]});
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    vec_t vt[13];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{1, 0, BASE + 30'd1, 32'h0,        1, 32'h0000_0002};
        vt[1]  = '{1, 0, BASE + 30'd3, 32'h0,        0, 32'h0};
        vt[2]  = '{1, 0, BASE + 30'd2, 32'h0,        1, 32'd207};
        vt[3]  = '{1, 0, BASE,         32'h0,        1, 32'h0};
        vt[4]  = '{0, 1, BASE + 30'd2, 32'hFFFF_0003, 0, 32'h0};
        vt[5]  = '{1, 0, BASE + 30'd2, 32'h0,        1, 32'h3};
        vt[6]  = '{1, 1, BASE + 30'd2, 32'h5,        1, 32'h3};
        vt[7]  = '{1, 0, BASE + 30'd2, 32'h0,        1, 32'h5};
        vt[8]  = '{0, 1, BASE + 30'd5, 32'h1234,     0, 32'h0};
        vt[9]  = '{0, 1, BASE - 30'd1, 32'h55,       0, 32'h0};
        vt[10] = '{1, 0, BASE + 30'd1, 32'h0,        1, 32'h0000_0002};
        vt[11] = '{1, 0, 30'h0,        32'h0,        0, 32'h0};
        vt[12] = '{0, 1, BASE + 30'd2, 32'h3,        0, 32'h0};

        // Reset state
        repeat (2) @(posedge clk); #1;
        chk("reset_txd", {31'b0, txd}, 32'd1);
        chk("reset_rsel", {31'b0, rsel}, 32'd0);
        chk("reset_rdata", rdata, 32'h0);
        do_reset();

        foreach (vt[i]) begin
            logic rs; logic [31:0] rd;
            bus(vt[i].r, vt[i].w, vt[i].a, vt[i].d, rs, rd);
            chk($sformatf("vec%0d_rsel", i), {31'b0, rs}, {31'b0, vt[i].exp_rsel});
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
        end

        // Single A5 frame at 4-cycle bits
        wr(BASE, 32'hA5);
        @(posedge clk); #1;
        check_frame(8'hA5, 4, 0);
        chk("a5_idle_txd", {31'b0, txd}, 32'd1);
        rd_chk("a5_status_idle", BASE + 30'd1, 32'h2);

        // Divisor change mid-frame applies to the following frame
        wr(BASE, 32'h3C);
        wr(BASE, 32'h81);
        fork
            check_frame(8'h3C, 4, 0);
            begin
                repeat (6) @(posedge clk);
                #1;
                wr(BASE + 30'd2, 32'h9);
            end
        join
        check_frame(8'h81, 10, 0);
        rd_chk("div_readback", BASE + 30'd2, 32'h9);
        wr(BASE + 30'd2, 32'h3);

        // Three queued frames, contiguous; busy clears right after the last stop bit
        wr(BASE, 32'h11);
        wr(BASE, 32'h22);
        wr(BASE, 32'h33);
        check_frame(8'h11, 4, 1);
        check_frame(8'h22, 4, 0);
        fork
            check_frame(8'h33, 4, 0);
            begin
                repeat (NB * 4 - 1) @(posedge clk);
                #1;
                rd_chk("last_stop_busy", BASE + 30'd1, 32'h6);
                rd_chk("after_stop_idle", BASE + 30'd1, 32'h2);
            end
        join

        // Overflow: FIFO_DEPTH+2 back-to-back writes
        for (int i = 0; i < 10; i++) wr(BASE, 32'h40 + i);
        rd_chk("ovf_status1", BASE + 30'd1, 32'h0000_080D);
        rd_chk("ovf_status2", BASE + 30'd1, 32'h0000_0805);

        // Reset asserted mid-DATA abandons the frame
        do_reset();
        wr(BASE + 30'd2, 32'h3);
        wr(BASE, 32'h00);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_data_txd", {31'b0, txd}, 32'd0);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_txd", {31'b0, txd}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        rd_chk("post_reset_status", BASE + 30'd1, 32'h2);
        begin
            int low_cnt;
            low_cnt = 0;
            for (int i = 0; i < 60; i++) begin
                if (txd !== 1'b1) low_cnt++;
                @(posedge clk); #1;
            end
            chk("no_residual_frame", low_cnt, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memio_uart_tx.md
MEMIO_UART_TX -- requirements
Module: memio_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, default 30'h44, word address of register 0; registers occupy BASE_ADDR..BASE_ADDR+2.
REQ-002 Parameter DIV_RESET, default 16'd207, reset value of DIVISOR; bit period = DIVISOR+1 clk cycles (115200 baud at 24 MHz).
REQ-003 Parameter FIFO_DEPTH, default 8, power of two, 2..64.
REQ-004 clk  input  1  sole clock; all state changes on posedge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 re  input  1  bus read strobe, same cycle as addr.
REQ-007 we  input  1  bus write strobe, same cycle as addr and wdata.
REQ-008 addr  input  30  bus word address.
REQ-009 wdata  input  32  bus write data.
REQ-010 rdata  output  32  registered read data; zero when not selected, so it can be ORed onto the shared read bus.
REQ-011 rsel  output  1  high for the one cycle in which rdata carries this block's data.
REQ-012 txd  output  1  serial line, idle high.

Function
REQ-013 Register map: offset 0 TXDATA (W), offset 1 STATUS (R), offset 2 DIVISOR (R/W, bits [15:0]).
REQ-014 Read latency is one cycle: re with addr hit at edge N drives rdata/rsel in the cycle after edge N; otherwise rdata=0, rsel=0.
REQ-015 TXDATA read returns 0. DIVISOR read returns {16'b0, DIVISOR}.
REQ-016 STATUS read returns: bit0 full, bit1 empty, bit2 busy (shifter not IDLE), bit3 overflow, bits[14:8] FIFO count, all other bits 0.
REQ-017 A STATUS read clears overflow in the same edge. An overflow set in that same edge wins, so overflow reads 1 next time.
REQ-018 A TXDATA write pushes wdata[7:0] into the FIFO if the FIFO is not full at that edge. Otherwise the byte is dropped and overflow is set.
REQ-019 A write while full is dropped even if a pop occurs in the same edge.
REQ-020 Writes and reads to addresses outside the map are ignored; re and we both asserted are each handled independently.
REQ-021 Shifter FSM: IDLE, START, DATA, PARITY (REQ-029 only), STOP.
REQ-022 IDLE: txd=1. When the FIFO is non-empty, pop the head into the shift register, latch DIVISOR as the frame period, and go to START.
REQ-023 START drives txd=0 for one period.
REQ-024 DATA drives 8 bits LSB first, one period each, using a 3-bit bit counter.
REQ-025 STOP drives txd=1 for one period, then goes to IDLE; the next frame's START begins on the very next edge when the FIFO is non-empty.
REQ-026 A DIVISOR write mid-frame does not affect the current frame; it applies from the next frame.
REQ-027 FIFO read/write pointers wrap modulo FIFO_DEPTH; count is FIFO_DEPTH when full; a push and pop in the same edge leave count unchanged.

Reset
REQ-028 rst low asynchronously forces: FSM=IDLE, txd=1, FIFO empty (pointers and count 0), overflow=0, DIVISOR=DIV_RESET, rdata=0, rsel=0. A frame in progress is abandoned without completing.

Configuration
REQ-029 Macro MEMIO_UART_TX_PARITY_EN defined: PARITY state inserted after DATA, driving even parity (XOR of the 8 data bits) for one period; frame is 11 bits. Macro undefined: no PARITY state; frame is 8N1 (10 bits).

Verification
REQ-030 Reset with DIVISOR=3, write 8'hA5 to TXDATA: txd = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (8N1); with the macro, a parity bit 0 precedes stop.
REQ-031 Write FIFO_DEPTH+2 bytes back to back at DIVISOR=3: the first 9 are accepted (one popped immediately), the rest are dropped. STATUS then reads overflow=1 and full=1; a second STATUS read shows overflow=0.
REQ-032 Read addr BASE_ADDR+1 after reset: rsel=1 and rdata=32'h0000_0002 one cycle later. Read addr BASE_ADDR+3: rsel=0, rdata=0.
REQ-033 Write DIVISOR=9 during a frame at DIVISOR=3: the current frame completes at 4-cycle bits; the next frame uses 10-cycle bits. DIVISOR reads back 32'h9.
REQ-034 Assert rst low mid-DATA: txd=1 immediately, STATUS=32'h2 after release, and no residual frame is sent.
REQ-035 Queue 3 bytes: the frames are contiguous, with no idle gap between STOP and the next START; busy drops one cycle after the last stop bit ends.
